// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light sequencer: mode codes, state codes,
// lamp patterns and the per-state lamp decode.
package traffic_pkg;

  localparam logic [1:0] MODE_NIGHT = 2'b00;
  localparam logic [1:0] MODE_DAY   = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [3:0] ST_RED_A     = 4'd0;
  localparam logic [3:0] ST_NS_G      = 4'd1;
  localparam logic [3:0] ST_NS_Y      = 4'd2;
  localparam logic [3:0] ST_RED_B     = 4'd3;
  localparam logic [3:0] ST_EW_G      = 4'd4;
  localparam logic [3:0] ST_EW_Y      = 4'd5;
  localparam logic [3:0] ST_PED_WALK  = 4'd6;
  localparam logic [3:0] ST_FLASH_ON  = 4'd7;
  localparam logic [3:0] ST_FLASH_OFF = 4'd8;
  localparam logic [3:0] ST_EMG_HOLD  = 4'd9;

  typedef enum logic [3:0] {
    RED_A     = ST_RED_A,
    NS_G      = ST_NS_G,
    NS_Y      = ST_NS_Y,
    RED_B     = ST_RED_B,
    EW_G      = ST_EW_G,
    EW_Y      = ST_EW_Y,
    PED_WALK  = ST_PED_WALK,
    FLASH_ON  = ST_FLASH_ON,
    FLASH_OFF = ST_FLASH_OFF,
    EMG_HOLD  = ST_EMG_HOLD
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {nsLight, ewLight}; anything not explicitly lit is all-red.
  function automatic logic [5:0] lampsFor(input state_t s);
    case (s)
      NS_G:      lampsFor = {LAMP_GRN, LAMP_RED};
      NS_Y:      lampsFor = {LAMP_YEL, LAMP_RED};
      EW_G:      lampsFor = {LAMP_RED, LAMP_GRN};
      EW_Y:      lampsFor = {LAMP_RED, LAMP_YEL};
      FLASH_ON:  lampsFor = {LAMP_YEL, LAMP_RED};
      FLASH_OFF: lampsFor = {LAMP_OFF, LAMP_OFF};
      default:   lampsFor = {LAMP_RED, LAMP_RED};
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; done flags the last cycle of a phase.
module phase_timer #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count down to zero and hold there; a load always wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= loadValue;
    end else if (count != {WIDTH{1'b0}}) begin
      count <= count - WIDTH'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == {WIDTH{1'b0}});

endmodule

// File: rtl/traffic_light_sequencer.sv
// Moore sequencer for a two-road intersection with pedestrian, night-flash and
// emergency preemption; every green leaves through its yellow.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 6,
  parameter int FLASH_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] trafficMode,
  output logic [2:0] nsLight,
  output logic [2:0] ewLight,
  output logic       walk,
  output logic [3:0] phase,
  output logic       pedPending
);

  localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_RW    = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
  localparam int MAX_GYRW  = (MAX_GY > MAX_RW) ? MAX_GY : MAX_RW;
  localparam int MAX_TICKS = (MAX_GYRW > FLASH_TICKS) ? MAX_GYRW : FLASH_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  state_t          state;
  state_t          nextState;
  logic            timerDone;
  logic            timerLoad;
  logic [TW-1:0]   timerValue;
  logic            resumeEw;   // walk was entered from RED_B, so EW_G follows it
  logic            pedBlock;   // mode held at 10 after a walk: wait for a red expiry
  logic            redExpiry;

  phase_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (TW'(ALLRED_TICKS - 1))
  ) timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timerLoad),
    .loadValue (timerValue),
    .done      (timerDone)
  );

  // Transition function; mode priority is emergency, night, then pedestrian/day.
  always_comb begin
    nextState = state;
    if (trafficMode == MODE_EMG) begin
      case (state)
        NS_G:       nextState = NS_Y;
        EW_G:       nextState = EW_Y;
        NS_Y, EW_Y: nextState = timerDone ? EMG_HOLD : state;
        default:    nextState = EMG_HOLD;
      endcase
    end else if (trafficMode == MODE_NIGHT) begin
      case (state)
        NS_G:                   nextState = NS_Y;
        EW_G:                   nextState = EW_Y;
        NS_Y:                   nextState = timerDone ? RED_B : NS_Y;
        EW_Y:                   nextState = timerDone ? RED_A : EW_Y;
        RED_A, RED_B, PED_WALK: nextState = timerDone ? FLASH_ON : state;
        FLASH_ON:               nextState = timerDone ? FLASH_OFF : FLASH_ON;
        FLASH_OFF:              nextState = timerDone ? FLASH_ON : FLASH_OFF;
        default:                nextState = RED_A;
      endcase
    end else begin
      case (state)
        RED_A:    nextState = timerDone ? (pedPending ? PED_WALK : NS_G) : RED_A;
        NS_G:     nextState = timerDone ? NS_Y : NS_G;
        NS_Y:     nextState = timerDone ? RED_B : NS_Y;
        RED_B:    nextState = timerDone ? (pedPending ? PED_WALK : EW_G) : RED_B;
        EW_G:     nextState = timerDone ? EW_Y : EW_G;
        EW_Y:     nextState = timerDone ? RED_A : EW_Y;
        PED_WALK: nextState = timerDone ? (resumeEw ? EW_G : NS_G) : PED_WALK;
        default:  nextState = RED_A;
      endcase
    end
  end

  // Phase length for the state being entered; EMG_HOLD ignores its timer.
  always_comb begin
    case (nextState)
      NS_G, EW_G:          timerValue = TW'(GREEN_TICKS - 1);
      NS_Y, EW_Y:          timerValue = TW'(YELLOW_TICKS - 1);
      RED_A, RED_B:        timerValue = TW'(ALLRED_TICKS - 1);
      PED_WALK:            timerValue = TW'(WALK_TICKS - 1);
      FLASH_ON, FLASH_OFF: timerValue = TW'(FLASH_TICKS - 1);
      default:             timerValue = {TW{1'b0}};
    endcase
  end

  assign timerLoad = (nextState != state);
  assign redExpiry = ((state == RED_A) || (state == RED_B)) && timerDone;

  // State register, registered lamp decode and pedestrian request bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RED_A;
      nsLight    <= LAMP_RED;
      ewLight    <= LAMP_RED;
      walk       <= 1'b0;
      pedPending <= 1'b0;
      resumeEw   <= 1'b0;
      pedBlock   <= 1'b0;
    end else begin
      state              <= nextState;
      {nsLight, ewLight} <= lampsFor(nextState);
      walk               <= (nextState == PED_WALK);
      if ((nextState == PED_WALK) && (state != PED_WALK)) begin
        pedPending <= 1'b0;
        pedBlock   <= 1'b1;
        resumeEw   <= (state == RED_B);
      end else begin
        if ((trafficMode == MODE_PED) && !pedBlock) begin
          pedPending <= 1'b1;
        end
        if ((trafficMode != MODE_PED) || redExpiry) begin
          pedBlock <= 1'b0;
        end
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with G=4, Y=2, R=1, W=3, F=2.
module tb_traffic_light_sequencer;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] trafficMode = 2'b01;
  logic [2:0] nsLight;
  logic [2:0] ewLight;
  logic       walk;
  logic [3:0] phase;
  logic       pedPending;
  logic [11:0] observed;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       r;
    logic [1:0] m;
    logic [3:0] p;
    logic       ped;
  } step_t;

  // Each step: rst/mode held during the cycle, then the state expected after the edge.
  step_t plan[$];

  traffic_light_sequencer #(
    .GREEN_TICKS  (4),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (3),
    .FLASH_TICKS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trafficMode (trafficMode),
    .nsLight     (nsLight),
    .ewLight     (ewLight),
    .walk        (walk),
    .phase       (phase),
    .pedPending  (pedPending)
  );

  always #5 clk = ~clk;

  assign observed = {phase, nsLight, ewLight, walk, pedPending};

  function automatic logic [11:0] expVec(input logic [3:0] p, input logic ped);
    logic [2:0] ns;
    logic [2:0] ew;
    logic       w;
    ns = 3'b100;
    ew = 3'b100;
    w  = 1'b0;
    case (p)
      ST_NS_G:      ns = 3'b001;
      ST_NS_Y:      ns = 3'b010;
      ST_EW_G:      ew = 3'b001;
      ST_EW_Y:      ew = 3'b010;
      ST_PED_WALK:  w  = 1'b1;
      ST_FLASH_ON:  ns = 3'b010;
      ST_FLASH_OFF: begin ns = 3'b000; ew = 3'b000; end
      default:      ns = 3'b100;
    endcase
    return {p, ns, ew, w, ped};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic r, input logic [1:0] m,
                     input logic [3:0] p, input logic ped);
    for (int k = 0; k < n; k++) plan.push_back('{r, m, p, ped});
  endtask

  task automatic doReset();
    rst = 1'b1;
    trafficMode = 2'b01;
    tick();
    tick();
    rst = 1'b0;
    plan.delete();
  endtask

  task automatic test_reset();
    logic [11:0] expected;
    rst = 1'b1;
    trafficMode = 2'b11;
    tick();
    tick();
    expected = expVec(ST_RED_A, 1'b0);
    total++;
    if (observed !== expected)
      $display("FAIL reset_state: got %b required %b", observed, expected);
    else passed++;
    rst = 1'b0;
    trafficMode = 2'b01;
  endtask

  task automatic test_day_cycle();
    logic [11:0] expected;
    doReset();
    add(4, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(2, 1'b0, 2'b01, ST_NS_Y, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_B, 1'b0);
    add(4, 1'b0, 2'b01, ST_EW_G, 1'b0);
    add(2, 1'b0, 2'b01, ST_EW_Y, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_A, 1'b0);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL day_cycle step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_ped_request();
    logic [11:0] expected;
    doReset();
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(1, 1'b0, 2'b10, ST_NS_G, 1'b1);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b1);
    add(2, 1'b0, 2'b01, ST_NS_Y, 1'b1);
    add(1, 1'b0, 2'b01, ST_RED_B, 1'b1);
    add(3, 1'b0, 2'b01, ST_PED_WALK, 1'b0);
    add(4, 1'b0, 2'b01, ST_EW_G, 1'b0);
    add(1, 1'b0, 2'b01, ST_EW_Y, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL ped_request step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_ped_held_mode();
    logic [11:0] expected;
    doReset();
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(3, 1'b0, 2'b10, ST_NS_G, 1'b1);
    add(2, 1'b0, 2'b10, ST_NS_Y, 1'b1);
    add(1, 1'b0, 2'b10, ST_RED_B, 1'b1);
    add(3, 1'b0, 2'b10, ST_PED_WALK, 1'b0);
    add(4, 1'b0, 2'b10, ST_EW_G, 1'b0);
    add(2, 1'b0, 2'b10, ST_EW_Y, 1'b0);
    add(1, 1'b0, 2'b10, ST_RED_A, 1'b0);
    add(1, 1'b0, 2'b10, ST_NS_G, 1'b0);
    add(1, 1'b0, 2'b10, ST_NS_G, 1'b1);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL ped_held_mode step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_emergency_green();
    logic [11:0] expected;
    doReset();
    add(4, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(2, 1'b0, 2'b01, ST_NS_Y, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_B, 1'b0);
    add(1, 1'b0, 2'b01, ST_EW_G, 1'b0);
    add(2, 1'b0, 2'b11, ST_EW_Y, 1'b0);
    add(3, 1'b0, 2'b11, ST_EMG_HOLD, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_A, 1'b0);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL emergency_green step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_emergency_walk();
    logic [11:0] expected;
    doReset();
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(1, 1'b0, 2'b10, ST_NS_G, 1'b1);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b1);
    add(2, 1'b0, 2'b01, ST_NS_Y, 1'b1);
    add(1, 1'b0, 2'b01, ST_RED_B, 1'b1);
    add(2, 1'b0, 2'b01, ST_PED_WALK, 1'b0);
    add(2, 1'b0, 2'b11, ST_EMG_HOLD, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_A, 1'b0);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL emergency_walk step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_night();
    logic [11:0] expected;
    doReset();
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(2, 1'b0, 2'b00, ST_NS_Y, 1'b0);
    add(1, 1'b0, 2'b00, ST_RED_B, 1'b0);
    add(2, 1'b0, 2'b00, ST_FLASH_ON, 1'b0);
    add(2, 1'b0, 2'b00, ST_FLASH_OFF, 1'b0);
    add(1, 1'b0, 2'b00, ST_FLASH_ON, 1'b0);
    add(1, 1'b0, 2'b01, ST_RED_A, 1'b0);
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL night step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  task automatic test_reset_midphase();
    logic [11:0] expected;
    doReset();
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    add(1, 1'b0, 2'b10, ST_NS_G, 1'b1);
    add(1, 1'b0, 2'b01, ST_NS_G, 1'b1);
    add(1, 1'b0, 2'b01, ST_NS_Y, 1'b1);
    add(1, 1'b1, 2'b01, ST_RED_A, 1'b0);
    add(2, 1'b0, 2'b01, ST_NS_G, 1'b0);
    foreach (plan[i]) begin
      rst = plan[i].r; trafficMode = plan[i].m; tick();
      expected = expVec(plan[i].p, plan[i].ped);
      total++;
      if (observed !== expected)
        $display("FAIL reset_midphase step %0d: got %b required %b", i, observed, expected);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_day_cycle();
    test_ped_request();
    test_ped_held_mode();
    test_emergency_green();
    test_emergency_walk();
    test_night();
    test_reset_midphase();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
